// File: rtl/param_updown_counter.sv
// Modulo-MOD up/down counter with clear, clamped load, terminal count and wrap pulse.
// Optional sticky overflow flag: define PARAM_UPDOWN_COUNTER_STICKY_OVF_EN.
module param_updown_counter #(
  parameter int unsigned     WIDTH = 4,
  parameter longint unsigned MOD   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef PARAM_UPDOWN_COUNTER_STICKY_OVF_EN
  input  logic             ovf_clr,
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // load comparison is one bit wider since the modulus may equal 2**WIDTH
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 64'd1);
  localparam logic [WIDTH:0]   MODX = (WIDTH+1)'(MOD);

  typedef enum logic [1:0] {OP_HOLD, OP_CLR, OP_LOAD, OP_STEP} op_e;

  op_e              op;
  logic             at_end;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  always_comb begin
    op       = OP_HOLD;
    at_end   = up_dn ? (q == MAXV) : (q == '0);
    tc       = en & at_end;
    q_nxt    = q;
    wrap_nxt = 1'b0;

    if (clr)       op = OP_CLR;
    else if (load) op = OP_LOAD;
    else if (en)   op = OP_STEP;

    unique case (op)
      OP_CLR:  q_nxt = '0;
      OP_LOAD: q_nxt = ({1'b0, load_val} < MODX) ? load_val : MAXV;
      OP_STEP: begin
        wrap_nxt = at_end;
        if (up_dn) q_nxt = at_end ? '0 : q + WIDTH'(1);
        else       q_nxt = at_end ? MAXV : q - WIDTH'(1);
      end
      default: q_nxt = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

`ifdef PARAM_UPDOWN_COUNTER_STICKY_OVF_EN
  // a wrap on the same edge as ovf_clr wins, so no overflow is lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            ovf <= 1'b0;
    else if (op == OP_CLR) ovf <= 1'b0;
    else if (wrap_nxt)   ovf <= 1'b1;
    else if (ovf_clr)    ovf <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_param_updown_counter.sv
// Randomized bench for param_updown_counter (WIDTH=4, MOD=10) against a modular-arithmetic model.
module tb_param_updown_counter;
  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, up_dn = 1'b0, clr = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic         tc, wrap;
`ifdef PARAM_UPDOWN_COUNTER_STICKY_OVF_EN
  logic         ovf_clr = 1'b0;
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  int mq    = 0;
  bit mwrap = 1'b0;
  bit movf  = 1'b0;

  param_updown_counter #(.WIDTH(W), .MOD(M)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val),
`ifdef PARAM_UPDOWN_COUNTER_STICKY_OVF_EN
    .ovf_clr(ovf_clr), .ovf(ovf),
`endif
    .q(q), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // reference: count kept as an integer, stepped with modulo arithmetic
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq = 0; mwrap = 1'b0; movf = 1'b0;
    end else begin
      if (clr) begin
        mq = 0; mwrap = 1'b0;
      end else if (load) begin
        mq = (int'(load_val) < M) ? int'(load_val) : M - 1;
        mwrap = 1'b0;
      end else if (en) begin
        mwrap = up_dn ? (mq == M - 1) : (mq == 0);
        mq = up_dn ? (mq + 1) % M : (mq + M - 1) % M;
      end else begin
        mwrap = 1'b0;
      end
`ifdef PARAM_UPDOWN_COUNTER_STICKY_OVF_EN
      if (clr)          movf = 1'b0;
      else if (mwrap)   movf = 1'b1;
      else if (ovf_clr) movf = 1'b0;
`endif
    end
  end

  always @(negedge clk) begin
    chk("q", q, mq);
    chk("tc", tc, en && (up_dn ? (mq == M - 1) : (mq == 0)));
    chk("wrap", wrap, mwrap);
    chk("q_range", q < M, 1);
`ifdef PARAM_UPDOWN_COUNTER_STICKY_OVF_EN
    chk("ovf", ovf, movf);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int seq_dn[5];
    seq_dn = '{2, 1, 0, 9, 8};

    #1;
    chk("rst_q", q, 0);
    chk("rst_wrap", wrap, 0);
    en = 1'b1; up_dn = 1'b0;
    #1 chk("rst_tc_dn", tc, 1);
    up_dn = 1'b1;
    #1 chk("rst_tc_up", tc, 0);
    tick();
    chk("held_rst_q", q, 0);
    rst = 1'b1;

    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("up_q", q, i % 10);
      chk("up_wrap", wrap, i == 10);
      chk("up_tc", tc, (i % 10) == 9);
    end

    en = 1'b0; load = 1'b1; load_val = 4'd3;
    tick();
    chk("load3_q", q, 3);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("dn_q", q, seq_dn[i]);
      chk("dn_wrap", wrap, seq_dn[i] == 9);
    end

    en = 1'b0; load = 1'b1; load_val = 4'd14;
    tick();
    chk("load_clamp_q", q, 9);
    clr = 1'b1; en = 1'b1; load_val = 4'd5;
    tick();
    chk("clr_prio_q", q, 0);
    chk("clr_prio_wrap", wrap, 0);
    clr = 1'b0; en = 1'b0;

    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick();
    chk("pre_rst_q", q, 6);
    #1 rst = 1'b0;
    #1 chk("async_rst_q", q, 0);
    chk("async_rst_wrap", wrap, 0);
    rst = 1'b1;
    tick();
    chk("post_rst_q", q, 1);

    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      up_dn = i[0];
      tick();
      chk("idle_q", q, 1);
      chk("idle_tc", tc, 0);
      chk("idle_wrap", wrap, 0);
    end

`ifdef PARAM_UPDOWN_COUNTER_STICKY_OVF_EN
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    tick();
    chk("ovf_set_q", q, 0);
    chk("ovf_set", ovf, 1);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("ovf_hold", ovf, 1);
    end
    load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; ovf_clr = 1'b1;
    tick();
    chk("ovf_set_prio", ovf, 1);
    chk("ovf_set_prio_wrap", wrap, 1);
    en = 1'b0;
    tick();
    chk("ovf_cleared", ovf, 0);
    ovf_clr = 1'b0;
`endif

    for (int n = 0; n < 3000; n++) begin
      tick();
      clr      = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = ($urandom_range(0, 9) < 6) ? (n[6] == 1'b0) : $urandom_range(0, 1) == 1;
      load_val = W'($urandom);
`ifdef PARAM_UPDOWN_COUNTER_STICKY_OVF_EN
      ovf_clr  = ($urandom_range(0, 7) == 0);
`endif
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
